// File: rtl/fifo_reader_if.sv
// Bundles the FIFO read port and the downstream valid/ready stream of fifo_reader.
// master: the reader engine; slave: the FIFO plus consumer environment.
interface fifo_reader_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_r_en;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  m_ready,
    output fifo_r_en,
    output m_valid,
    output m_data
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output m_ready,
    input  fifo_r_en,
    input  m_valid,
    input  m_data
  );

endinterface

// File: rtl/fifo_reader.sv
// Read-side engine for the synchronous fifo: issues r_en, absorbs the one-cycle
// read latency and re-presents words on a valid/ready stream at full throughput.
// Optional pop counter enabled by defining FIFO_READER_CNT_EN.
module fifo_reader #(
  parameter int unsigned DATA_WIDTH = 8
`ifdef FIFO_READER_CNT_EN
  , parameter int unsigned CNT_WIDTH = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rd_enable,
  input  logic                 flush,
`ifdef FIFO_READER_CNT_EN
  input  logic                 cnt_clear,
  output logic [CNT_WIDTH-1:0] pop_count,
`endif
  fifo_reader_if.master        bus
);

  // Buffer occupancy doubles as the control state.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  occ_e                  state_q;
  occ_e                  state_d;
  logic [1:0]            occ;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic                  pop;
  logic                  capture;
  logic [2:0]            pending;
  logic                  r_en_c;

  assign occ         = 2'(state_q);
  assign bus.m_valid = (state_q != OCC_EMPTY);
  assign bus.m_data  = head_q;

  // A word lands one cycle after its read; a flush in that cycle drops it.
  assign pop     = bus.m_valid & bus.m_ready;
  assign capture = inflight_q & ~flush;

  // Slots already committed (held + landing) minus the one leaving this cycle.
  // The m_ready -> fifo_r_en path is deliberate: it sustains one word per cycle.
  assign pending = 3'(occ) + 3'(inflight_q) - 3'(pop);
  assign r_en_c  = rst_n & rd_enable & ~bus.fifo_empty & ~flush & (pending < 3'd2);
  assign bus.fifo_r_en = r_en_c;

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OCC_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Occupancy next state: flush empties, capture fills, pop drains.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case ({capture, pop})
        2'b10: begin
          case (state_q)
            OCC_EMPTY: state_d = OCC_ONE;
            OCC_ONE:   state_d = OCC_TWO;
            default:   state_d = OCC_TWO;
          endcase
        end
        2'b01: begin
          case (state_q)
            OCC_TWO: state_d = OCC_ONE;
            default: state_d = OCC_EMPTY;
          endcase
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Read-in-flight flag; flush already forces r_en_c low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= r_en_c;
    end
  end

  // Head/tail buffer: pop shifts tail forward, capture fills the first free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else if (!flush) begin
      if (pop) begin
        if (state_q == OCC_TWO) begin
          head_q <= tail_q;
        end
        if (capture) begin
          if (state_q == OCC_TWO) begin
            tail_q <= bus.fifo_data;
          end else begin
            head_q <= bus.fifo_data;
          end
        end
      end else if (capture) begin
        if (state_q == OCC_EMPTY) begin
          head_q <= bus.fifo_data;
        end else begin
          tail_q <= bus.fifo_data;
        end
      end
    end
  end

`ifdef FIFO_READER_CNT_EN
  logic [CNT_WIDTH-1:0] pop_count_q;

  // Accepted-word counter; clear wins over increment, flush cycles never count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_count_q <= '0;
    end else if (cnt_clear) begin
      pop_count_q <= '0;
    end else if (pop && !flush) begin
      pop_count_q <= pop_count_q + CNT_WIDTH'(1);
    end
  end

  assign pop_count = pop_count_q;
`endif

endmodule
